// File: rtl/write_back_buffered.sv
// Buffered write-back stage: result select, optional load extension (LOAD_EXT_EN),
// DEPTH-entry FIFO towards the register-file write port, and a retire counter.
module write_back_buffered #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] ext_const,
   input  logic [DATA_W-1:0] load_data,
   input  logic [DATA_W-1:0] pc_plus4,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_reg_write,
   input  logic [1:0]        in_ld_size,
   input  logic              in_ld_unsigned,
   input  logic [1:0]        in_byte_off,
   input  logic              rf_ready,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [CNT_W-1:0]  retire_cnt
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // Input side: in_valid/in_ready, in_ready from registered occupancy only.
   // Output side: rf_we acts as valid towards rf_ready; non-writing entries retire without rf_ready.

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [OCC_W-1:0]  count;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [REG_AW-1:0] mem_rd   [DEPTH];
   logic              mem_we   [DEPTH];

   logic [DATA_W-1:0] load_ext;
   logic [DATA_W-1:0] result;
   logic              we_eff;
   logic              head_valid;
   logic              head_we;
   logic              push;
   logic              pop;

`ifdef LOAD_EXT_EN
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte  = load_data[{in_byte_off, 3'b000} +: 8];
      ld_half  = load_data[{in_byte_off[1], 4'b0000} +: 16];
      load_ext = load_data;
      case (in_ld_size)
         2'b00:   load_ext = {{(DATA_W-8){~in_ld_unsigned & ld_byte[7]}}, ld_byte};
         2'b01:   load_ext = {{(DATA_W-16){~in_ld_unsigned & ld_half[15]}}, ld_half};
         default: load_ext = load_data;
      endcase
   end
`else
   logic unused_ld_ctrl;
   assign unused_ld_ctrl = ^{in_ld_size, in_ld_unsigned, in_byte_off};
   assign load_ext       = load_data;
`endif

   always_comb begin
      result = ext_const;
      case (in_sel)
         2'b00:   result = ext_const;
         2'b01:   result = alu_result;
         2'b10:   result = load_ext;
         default: result = pc_plus4;
      endcase
   end

   // x0 is hard-wired zero, so a write to it is dropped at enqueue time.
   assign we_eff     = in_reg_write & (in_rd != '0);

   assign head_valid = (count != '0);
   assign head_we    = head_valid & mem_we[rd_ptr];
   assign in_ready   = (count < OCC_W'(DEPTH));
   assign push       = in_valid & in_ready;
   assign pop        = head_valid & (rf_ready | ~head_we);

   assign rf_we      = head_we;
   assign rf_waddr   = head_valid ? mem_rd[rd_ptr]   : '0;
   assign rf_wdata   = head_valid ? mem_data[rd_ptr] : '0;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= result;
         mem_rd[wr_ptr]   <= in_rd;
         mem_we[wr_ptr]   <= we_eff;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         retire_cnt <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop) begin
            rd_ptr     <= next_ptr(rd_ptr);
            retire_cnt <= retire_cnt + CNT_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
